// File: rtl/gpu_wb_pkg.sv
// Shared types for the pixel write buffer.
// Holds line geometry, the line record and the drain state encoding.
package gpu_wb_pkg;

  localparam int BLOCK_PIXELS = 8;
  localparam int TAG_W        = 16;
  localparam int PIX_W        = 16;
  localparam int SLOT_W       = 3;

  typedef struct packed {
    logic [TAG_W-1:0]                   tag;
    logic [BLOCK_PIXELS-1:0][PIX_W-1:0] data;
    logic [BLOCK_PIXELS-1:0]            mask;
  } line_t;

  typedef enum logic {
    DR_IDLE  = 1'b0,
    DR_WRITE = 1'b1
  } drain_st_e;

  // Empty line takes the pixel's tag; a filled slot is overwritten.
  function automatic line_t line_put(
    input line_t             l,
    input logic [TAG_W-1:0]  tag,
    input logic [SLOT_W-1:0] slot,
    input logic [PIX_W-1:0]  col
  );
    line_t r;
    r = l;
    if (l.mask == '0) r.tag = tag;
    r.data[slot] = col;
    r.mask[slot] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/gpu_wb_line.sv
// One 8-pixel write-combining line: tag compare, slot write, mask, clear.
// Ports: clk/i_nrst, i_clr/i_wr/i_load ops, pixel tag/slot/color, o_line/o_hit/o_empty.
import gpu_wb_pkg::*;

module gpu_wb_line (
  input  logic              clk,
  input  logic              i_nrst,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic              i_load,
  input  line_t             i_load_line,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [SLOT_W-1:0] i_slot,
  input  logic [PIX_W-1:0]  i_color,
  output line_t             o_line,
  output logic              o_hit,
  output logic              o_empty
);

  logic [BLOCK_PIXELS-1:0]            mask_q, mask_d;
  logic [TAG_W-1:0]                   tag_q, tag_d;
  logic [BLOCK_PIXELS-1:0][PIX_W-1:0] data_q, data_d;
  line_t                              nxt;

  always_comb begin
    o_line.tag  = tag_q;
    o_line.data = data_q;
    o_line.mask = mask_q;
    nxt = o_line;
    // clear then write starts a fresh line in the same cycle
    if (i_clr) nxt.mask = '0;
    if (i_wr) nxt = line_put(nxt, i_tag, i_slot, i_color);
    if (i_load) nxt = i_load_line;
    mask_d = nxt.mask;
    tag_d  = nxt.tag;
    data_d = nxt.data;
  end

  assign o_empty = (mask_q == '0);
  assign o_hit   = !o_empty && (tag_q == i_tag);

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) mask_q <= '0;
    else         mask_q <= mask_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/gpu_pixel_write_buffer.sv
// Combines final pixels into 8-pixel VRAM block writes.
// Ports: pixel in (i_valid/i_scrX/i_scrY/i_color/i_flush, o_stall), o_busy,
// write out (o_wrReq/o_wrAdr/o_wrData/o_wrMask, i_wrAck). Macro GPU_WB_DOUBLE_BUFFER_EN.
import gpu_wb_pkg::*;

module gpu_pixel_write_buffer (
  input  logic         clk,
  input  logic         i_nrst,
  input  logic         i_valid,
  input  logic [9:0]   i_scrX,
  input  logic [8:0]   i_scrY,
  input  logic [15:0]  i_color,
  input  logic         i_flush,
  output logic         o_stall,
  output logic         o_busy,
  output logic         o_wrReq,
  output logic [15:0]  o_wrAdr,
  output logic [127:0] o_wrData,
  output logic [7:0]   o_wrMask,
  input  logic         i_wrAck
);

  drain_st_e         state_q;
  logic              req_q, flp_q, flp_d;
  logic [TAG_W-1:0]  pix_tag;
  logic [SLOT_W-1:0] slot;
  logic              fl, busy_dr, ack;
  logic              miss, accept, trig;
  line_t             fill_l, drn_l;
  logic              fill_hit, fill_empty, dr_empty;

  assign pix_tag = {i_scrY, i_scrX[9:3]};
  assign slot    = i_scrX[2:0];
  assign fl      = i_flush | flp_q;
  assign busy_dr = (state_q == DR_WRITE);
  assign ack     = busy_dr & i_wrAck;

`ifdef GPU_WB_DOUBLE_BUFFER_EN
  logic  miss_swap, fl_swap, fill_wr, dr_hit;
  line_t drn_ld;

  always_comb begin
    miss      = !fill_empty && !fill_hit;
    o_stall   = i_valid & miss & busy_dr;
    accept    = i_valid & ~o_stall;
    miss_swap = i_valid & miss & ~busy_dr;
    fl_swap   = fl & ~busy_dr & ~miss_swap
              & (~fill_empty | accept);
    trig      = miss_swap | fl_swap;
    // flush swap carries this cycle's pixel into the drain line
    fill_wr   = accept & ~fl_swap;
    drn_ld    = fill_l;
    if (fl_swap && accept)
      drn_ld = line_put(fill_l, pix_tag, slot, i_color);
    flp_d     = fl & (busy_dr | miss_swap);
  end

  gpu_wb_line u_fill (
    .clk         (clk),
    .i_nrst      (i_nrst),
    .i_clr       (trig),
    .i_wr        (fill_wr),
    .i_load      (1'b0),
    .i_load_line ('0),
    .i_tag       (pix_tag),
    .i_slot      (slot),
    .i_color     (i_color),
    .o_line      (fill_l),
    .o_hit       (fill_hit),
    .o_empty     (fill_empty)
  );

  gpu_wb_line u_drain (
    .clk         (clk),
    .i_nrst      (i_nrst),
    .i_clr       (ack),
    .i_wr        (1'b0),
    .i_load      (trig),
    .i_load_line (drn_ld),
    .i_tag       (pix_tag),
    .i_slot      (slot),
    .i_color     (i_color),
    .o_line      (drn_l),
    .o_hit       (dr_hit),
    .o_empty     (dr_empty)
  );

  logic unused_dr;
  assign unused_dr = dr_hit;
`else
  // the single line is frozen while it drains, so every pixel misses
  always_comb begin
    miss    = busy_dr | (!fill_empty && !fill_hit);
    o_stall = i_valid & miss;
    accept  = i_valid & ~miss;
    trig    = ~busy_dr & ((i_valid & miss)
            | (fl & (~fill_empty | accept)));
    flp_d   = fl & (busy_dr | (i_valid & miss));
  end

  gpu_wb_line u_fill (
    .clk         (clk),
    .i_nrst      (i_nrst),
    .i_clr       (ack),
    .i_wr        (accept),
    .i_load      (1'b0),
    .i_load_line ('0),
    .i_tag       (pix_tag),
    .i_slot      (slot),
    .i_color     (i_color),
    .o_line      (fill_l),
    .o_hit       (fill_hit),
    .o_empty     (fill_empty)
  );

  assign drn_l    = fill_l;
  assign dr_empty = fill_empty;
`endif

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= DR_IDLE;
      req_q   <= 1'b0;
      flp_q   <= 1'b0;
    end else begin
      flp_q <= flp_d;
      unique case (state_q)
        DR_IDLE: if (trig) begin
          state_q <= DR_WRITE;
          req_q   <= 1'b1;
        end
        DR_WRITE: if (i_wrAck) begin
          state_q <= DR_IDLE;
          req_q   <= 1'b0;
        end
        default: begin
          state_q <= DR_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_wrReq  = req_q;
  assign o_wrAdr  = req_q ? drn_l.tag  : '0;
  assign o_wrData = req_q ? drn_l.data : '0;
  assign o_wrMask = req_q ? drn_l.mask : '0;
  assign o_busy   = ~fill_empty | ~dr_empty | req_q | flp_q;

endmodule

// File: tb/tb_gpu_pixel_write_buffer.sv
// Directed bench for gpu_pixel_write_buffer.
// Expected block writes are queued at stimulus time and matched to observed writes.
module tb_gpu_pixel_write_buffer;

  logic         clk = 1'b0;
  logic         i_nrst;
  logic         i_valid;
  logic [9:0]   i_scrX;
  logic [8:0]   i_scrY;
  logic [15:0]  i_color;
  logic         i_flush;
  logic         o_stall;
  logic         o_busy;
  logic         o_wrReq;
  logic [15:0]  o_wrAdr;
  logic [127:0] o_wrData;
  logic [7:0]   o_wrMask;
  logic         i_wrAck;
  logic         auto_ack;
  logic         ack_man;

`ifdef GPU_WB_DOUBLE_BUFFER_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 6;
`endif

  typedef struct packed {
    logic [15:0]  adr;
    logic [7:0]   mask;
    logic [127:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  assign i_wrAck = auto_ack ? o_wrReq : ack_man;

  gpu_pixel_write_buffer dut (
    .clk      (clk),
    .i_nrst   (i_nrst),
    .i_valid  (i_valid),
    .i_scrX   (i_scrX),
    .i_scrY   (i_scrY),
    .i_color  (i_color),
    .i_flush  (i_flush),
    .o_stall  (o_stall),
    .o_busy   (o_busy),
    .o_wrReq  (o_wrReq),
    .o_wrAdr  (o_wrAdr),
    .o_wrData (o_wrData),
    .o_wrMask (o_wrMask),
    .i_wrAck  (i_wrAck)
  );

  always @(negedge clk) begin
    wr_t w;
    if (i_nrst && o_wrReq && i_wrAck) begin
      w.adr  = o_wrAdr;
      w.mask = o_wrMask;
      w.data = o_wrData;
      obs_q.push_back(w);
    end
  end

  function automatic logic [127:0] keep(
    input logic [127:0] d, input logic [7:0] m);
    logic [127:0] r;
    r = d;
    for (int k = 0; k < 8; k++)
      if (!m[k]) r[16*k +: 16] = 16'h0;
    return r;
  endfunction

  function automatic logic [127:0] pd(
    input int k, input logic [15:0] c);
    logic [127:0] r;
    r = '0;
    r[16*k +: 16] = c;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] o,
                     input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", nm, o, e);
    end
  endtask

  task automatic push_exp(input logic [15:0] a,
                          input logic [7:0] m,
                          input logic [127:0] d);
    wr_t w;
    w.adr  = a;
    w.mask = m;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_px(input logic [9:0] x,
                        input logic [8:0] y,
                        input logic [15:0] c,
                        input logic fl);
    logic acc;
    acc = 1'b0;
    i_valid = 1'b1;
    i_scrX  = x;
    i_scrY  = y;
    i_color = c;
    i_flush = fl;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = !o_stall;
      step();
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("px_accept", {127'b0, acc}, 128'd1);
  endtask

  task automatic flush();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clk);
      idle = !o_busy;
      step();
    end
    chk(nm, {127'b0, idle}, 128'd1);
  endtask

  task automatic check_writes(input string nm);
    wr_t e, o;
    chk({nm, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({nm, "_adr"},  128'(o.adr),  128'(e.adr));
      chk({nm, "_mask"}, 128'(o.mask), 128'(e.mask));
      chk({nm, "_data"}, keep(o.data, e.mask), e.data);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [127:0] d;
    logic         acc;
    logic         seen;
    int           stalls;

    i_nrst   = 1'b0;
    i_valid  = 1'b1;
    i_scrX   = 10'd8;
    i_scrY   = 9'd1;
    i_color  = 16'hFFFF;
    i_flush  = 1'b0;
    auto_ack = 1'b1;
    ack_man  = 1'b0;

    // reset state
    #12;
    chk("rst_wrReq", 128'(o_wrReq), 128'd0);
    chk("rst_busy",  128'(o_busy),  128'd0);
    chk("rst_stall", 128'(o_stall), 128'd0);
    chk("rst_adr",   128'(o_wrAdr), 128'd0);
    chk("rst_mask",  128'(o_wrMask), 128'd0);
    chk("rst_data",  o_wrData, 128'd0);
    i_valid = 1'b0;
    step();
    i_nrst = 1'b1;
    step();

    // full line X=8..15, Y=3
    d = '0;
    for (int k = 0; k < 8; k++) d |= pd(k, 16'hA000 + 16'(k));
    push_exp(16'h0181, 8'hFF, d);
    for (int k = 0; k < 8; k++)
      put_px(10'(8 + k), 9'd3, 16'hA000 + 16'(k), 1'b0);
    flush();
    wait_idle("full_idle");
    check_writes("full");

    // same slot twice, last write wins
    push_exp(16'h0000, 8'h04, pd(2, 16'h2222));
    put_px(10'd2, 9'd0, 16'h1111, 1'b0);
    put_px(10'd2, 9'd0, 16'h2222, 1'b0);
    flush();
    wait_idle("dup_idle");
    check_writes("dup");

    // flush with nothing buffered
    i_flush = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("empty_busy",  128'(o_busy),  128'd0);
      chk("empty_wrReq", 128'(o_wrReq), 128'd0);
      step();
      i_flush = 1'b0;
    end
    check_writes("empty");

    // valid and flush together
    push_exp(16'h0380, 8'h20, pd(5, 16'hBEEF));
    put_px(10'd5, 9'd7, 16'hBEEF, 1'b1);
    wait_idle("vf_idle");
    check_writes("vf");

    // two lines, second is a miss
    push_exp(16'h0102, 8'h03,
             pd(0, 16'h0C00) | pd(1, 16'h0C01));
    push_exp(16'h0105, 8'h01, pd(0, 16'h0C02));
    put_px(10'd16, 9'd2, 16'h0C00, 1'b0);
    put_px(10'd17, 9'd2, 16'h0C01, 1'b0);
    put_px(10'd40, 9'd2, 16'h0C02, 1'b0);
    flush();
    wait_idle("miss_idle");
    check_writes("miss");

    // miss with a slow arbiter
    push_exp(16'h0000, 8'h01, pd(0, 16'h1234));
    push_exp(16'h0001, 8'h01, pd(0, 16'h5678));
    auto_ack = 1'b0;
    put_px(10'd0, 9'd0, 16'h1234, 1'b0);
    i_valid = 1'b1;
    i_scrX  = 10'd8;
    i_scrY  = 9'd0;
    i_color = 16'h5678;
    stalls  = 0;
    acc     = 1'b0;
    for (int n = 0; n < 10; n++) begin
      ack_man = (n == 5);
      @(negedge clk);
      if (i_valid) begin
        if (o_stall) stalls++;
        else acc = 1'b1;
      end
      step();
      if (acc) i_valid = 1'b0;
    end
    i_valid  = 1'b0;
    ack_man  = 1'b0;
    auto_ack = 1'b1;
    chk("slow_accept", {127'b0, acc}, 128'd1);
    chk("slow_stalls", 128'(stalls), 128'(EXP_STALL));
    flush();
    wait_idle("slow_idle");
    check_writes("slow");

    // reset in the middle of a write
    auto_ack = 1'b0;
    put_px(10'd0, 9'd1, 16'h7777, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = o_wrReq;
      if (!seen) step();
    end
    chk("mid_req_seen", {127'b0, seen}, 128'd1);
    #2;
    i_nrst = 1'b0;
    #1;
    chk("mid_wrReq", 128'(o_wrReq),  128'd0);
    chk("mid_busy",  128'(o_busy),   128'd0);
    chk("mid_mask",  128'(o_wrMask), 128'd0);
    step();
    i_nrst   = 1'b1;
    auto_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_wrReq", 128'(o_wrReq), 128'd0);
      step();
    end
    check_writes("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
